// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared constants and FSM encoding for the decode-stage scoreboard
package hazard_scoreboard_pkg;

    // Architectural register file geometry
    localparam int DEF_REG_COUNT    = 16;
    localparam int DEF_ADDR_W       = 4;

    // In-flight tracking: ID->EXE->MEM->WB allows at most three pending writes
    localparam int DEF_CNT_W        = 2;
    localparam int DEF_MAX_INFLIGHT = 3;

    // Cycles flush stays asserted after a taken branch, counting the branch cycle
    localparam int DEF_FLUSH_CYCLES = 1;

    // Sequencing FSM: normal issue, or squashing the wrong-path fetch stream
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fsm_e;

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// sb_counter: saturating up/down in-flight write counter with over/underflow detect
module sb_counter
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int MAX   = DEF_MAX_INFLIGHT
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic dec_i,
    output logic zero_o,
    output logic err_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             up, dn, ovf, unf;

    // Simultaneous inc and dec cancel; out-of-range moves hold and flag an error
    always_comb begin
        up     = inc_i & ~dec_i;
        dn     = dec_i & ~inc_i;
        ovf    = up & (cnt_q == CNT_W'(MAX));
        unf    = dn & (cnt_q == '0);
        cnt_d  = (ovf | unf) ? cnt_q : up ? cnt_q + 1'b1 : dn ? cnt_q - 1'b1 : cnt_q;
        zero_o = (cnt_q == '0);
        err_o  = ovf | unf;
    end

    // Counter state
    always_ff @(posedge clk) begin
        cnt_q <= rst ? '0 : cnt_d;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW stall and branch-flush sequencing for the ID stage
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_COUNT    = DEF_REG_COUNT,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [ADDR_W-1:0]    src_1,
    input  logic [ADDR_W-1:0]    src_2,
    input  logic                 two_src,
    input  logic                 id_wb_en,
    input  logic [ADDR_W-1:0]    id_dest,
    input  logic                 id_s,
    input  logic                 id_uses_sr,
    input  logic                 branch_taken,
    input  logic                 wb_en,
    input  logic [ADDR_W-1:0]    wb_dest,
    input  logic                 wb_sr_en,
    output logic                 hazard,
    output logic                 flush,
    output logic                 issue,
    output logic [REG_COUNT-1:0] busy_mask,
    output logic                 sb_error
);

    localparam int FL_W = $clog2(FLUSH_CYCLES + 1);

    logic [REG_COUNT-1:0] reg_zero, reg_err, busy;
    logic                 sr_zero, sr_err;
    fsm_e                 state_q;
    logic [FL_W-1:0]      fl_cnt_q;
    logic                 sb_error_q;
    logic                 flush_raw, haz_raw, issue_raw;

    // One counter per architectural register; WB retires, issue allocates
    for (genvar i = 0; i < REG_COUNT; i++) begin : g_reg
        sb_counter #(
            .CNT_W (CNT_W),
            .MAX   (MAX_INFLIGHT)
        ) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .inc_i  (issue & id_wb_en & (id_dest == ADDR_W'(i))),
            .dec_i  (wb_en & (wb_dest == ADDR_W'(i))),
            .zero_o (reg_zero[i]),
            .err_o  (reg_err[i])
        );
    end

    // Status register is tracked as one extra pending-write counter
    sb_counter #(
        .CNT_W (CNT_W),
        .MAX   (MAX_INFLIGHT)
    ) u_sr_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (issue & id_s),
        .dec_i  (wb_sr_en),
        .zero_o (sr_zero),
        .err_o  (sr_err)
    );

    // Same-cycle stall/flush/issue; no WB bypass, so a retiring write still stalls
    always_comb begin
        busy      = ~reg_zero;
        flush_raw = branch_taken | (state_q == FLUSH);
        haz_raw   = id_valid & ~flush_raw &
                    (busy[src_1] | (two_src & busy[src_2]) | (id_uses_sr & ~sr_zero));
        issue_raw = id_valid & ~haz_raw & ~flush_raw;
    end

    assign hazard    = ~rst & haz_raw;
    assign flush     = ~rst & flush_raw;
    assign issue     = ~rst & issue_raw;
    assign busy_mask = rst ? '0 : busy;
    assign sb_error  = sb_error_q;

    // Flush sequencer: a taken branch (re)loads the hold count; flush spans FLUSH_CYCLES cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            fl_cnt_q <= '0;
        end else if (branch_taken) begin
            state_q  <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            fl_cnt_q <= FL_W'(FLUSH_CYCLES - 1);
        end else if (state_q == FLUSH) begin
            state_q  <= (fl_cnt_q > FL_W'(1)) ? FLUSH : RUN;
            fl_cnt_q <= fl_cnt_q - 1'b1;
        end
    end

    // Sticky bookkeeping error; only reset clears it
    always_ff @(posedge clk) begin
        sb_error_q <= rst ? 1'b0 : (sb_error_q | (|reg_err) | sr_err);
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector table plus randomized run against a reference model
module tb_hazard_scoreboard;

    localparam int FC   = 2;
    localparam int MAXI = 3;

    logic        clk = 1'b0;
    logic        rst, id_valid, two_src, id_wb_en, id_s, id_uses_sr, branch_taken, wb_en, wb_sr_en;
    logic [3:0]  src_1, src_2, id_dest, wb_dest;
    logic        hazard, flush, issue, sb_error;
    logic [15:0] busy_mask;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .REG_COUNT    (16),
        .ADDR_W       (4),
        .CNT_W        (2),
        .MAX_INFLIGHT (MAXI),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .src_1        (src_1),
        .src_2        (src_2),
        .two_src      (two_src),
        .id_wb_en     (id_wb_en),
        .id_dest      (id_dest),
        .id_s         (id_s),
        .id_uses_sr   (id_uses_sr),
        .branch_taken (branch_taken),
        .wb_en        (wb_en),
        .wb_dest      (wb_dest),
        .wb_sr_en     (wb_sr_en),
        .hazard       (hazard),
        .flush        (flush),
        .issue        (issue),
        .busy_mask    (busy_mask),
        .sb_error     (sb_error)
    );

    typedef struct packed {
        logic       rst;
        logic       v;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       two;
        logic       wen;
        logic [3:0] dst;
        logic       s;
        logic       usr;
        logic       br;
        logic       wben;
        logic [3:0] wbd;
        logic       wbsr;
    } in_t;

    typedef struct {
        in_t         x;
        logic        h;
        logic        f;
        logic        i;
        logic [15:0] b;
        logic        e;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: pending-write counts as plain integers, remaining flush cycles
    int   mcnt[16];
    int   msr;
    int   mfl;
    bit   merr;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic in_t mi(input int r, input int v, input int s1, input int s2, input int two,
                               input int wen, input int dst, input int s, input int usr, input int br,
                               input int wben, input int wbd, input int wbsr);
        in_t x;
        x.rst  = r[0];
        x.v    = v[0];
        x.s1   = 4'(s1);
        x.s2   = 4'(s2);
        x.two  = two[0];
        x.wen  = wen[0];
        x.dst  = 4'(dst);
        x.s    = s[0];
        x.usr  = usr[0];
        x.br   = br[0];
        x.wben = wben[0];
        x.wbd  = 4'(wbd);
        x.wbsr = wbsr[0];
        return x;
    endfunction

    task automatic add(input in_t x, input logic h, input logic f, input logic i,
                       input logic [15:0] b, input logic e);
        vec_t v;
        v.x = x; v.h = h; v.f = f; v.i = i; v.b = b; v.e = e;
        tbl.push_back(v);
    endtask

    task automatic upd(inout int c, input int d);
        if (d > 0) begin
            if (c == MAXI) merr = 1'b1;
            else c++;
        end else if (d < 0) begin
            if (c == 0) merr = 1'b1;
            else c--;
        end
    endtask

    task automatic model_reset();
        foreach (mcnt[k]) mcnt[k] = 0;
        msr  = 0;
        mfl  = 0;
        merr = 1'b0;
    endtask

    // One clock: drive, check mid-cycle against model (and table if given), advance model at the edge
    task automatic step(input in_t x, input bit t, input logic h, input logic f, input logic i,
                        input logic [15:0] b, input logic e);
        logic [15:0] mb;
        logic        mf, mh, mis;
        int          inc, dec;
        rst = x.rst; id_valid = x.v; src_1 = x.s1; src_2 = x.s2; two_src = x.two;
        id_wb_en = x.wen; id_dest = x.dst; id_s = x.s; id_uses_sr = x.usr;
        branch_taken = x.br; wb_en = x.wben; wb_dest = x.wbd; wb_sr_en = x.wbsr;
        #4;
        for (int k = 0; k < 16; k++) mb[k] = !x.rst && mcnt[k] != 0;
        mf  = !x.rst && (x.br || mfl > 0);
        mh  = !x.rst && x.v && !mf &&
              (mcnt[x.s1] != 0 || (x.two && mcnt[x.s2] != 0) || (x.usr && msr != 0));
        mis = !x.rst && x.v && !mh && !mf;
        chk("model_hazard", {15'd0, hazard}, {15'd0, mh});
        chk("model_flush", {15'd0, flush}, {15'd0, mf});
        chk("model_issue", {15'd0, issue}, {15'd0, mis});
        chk("model_busy_mask", busy_mask, mb);
        chk("model_sb_error", {15'd0, sb_error}, {15'd0, merr});
        if (t) begin
            chk("vec_hazard", {15'd0, hazard}, {15'd0, h});
            chk("vec_flush", {15'd0, flush}, {15'd0, f});
            chk("vec_issue", {15'd0, issue}, {15'd0, i});
            chk("vec_busy_mask", busy_mask, b);
            chk("vec_sb_error", {15'd0, sb_error}, {15'd0, e});
        end
        @(posedge clk);
        if (x.rst) model_reset();
        else begin
            for (int k = 0; k < 16; k++) begin
                inc = (mis && x.wen && x.dst == 4'(k)) ? 1 : 0;
                dec = (x.wben && x.wbd == 4'(k)) ? 1 : 0;
                upd(mcnt[k], inc - dec);
            end
            upd(msr, ((mis && x.s) ? 1 : 0) - (x.wbsr ? 1 : 0));
            mfl = x.br ? FC - 1 : (mfl > 0 ? mfl - 1 : 0);
        end
        #1;
    endtask

    initial begin
        in_t x;
        int  base;
        // rst, v, s1, s2, two, wen, dst, s, usr, br, wben, wbd, wbsr  ->  hazard, flush, issue, busy, err
        add(mi(1,1,0,0,0,0,0,0,0,1,0,0,0), 0,0,0,16'h0000,0);
        add(mi(0,1,0,0,0,1,1,0,0,0,0,0,0), 0,0,1,16'h0000,0);
        add(mi(0,1,1,0,0,0,0,0,0,0,0,0,0), 1,0,0,16'h0002,0);
        add(mi(0,1,1,0,0,0,0,0,0,0,1,1,0), 1,0,0,16'h0002,0);
        add(mi(0,1,1,0,0,0,0,0,0,0,0,0,0), 0,0,1,16'h0000,0);
        add(mi(0,1,0,0,0,1,2,0,0,0,0,0,0), 0,0,1,16'h0000,0);
        add(mi(0,1,0,2,0,0,0,0,0,0,0,0,0), 0,0,1,16'h0004,0);
        add(mi(0,1,0,2,1,0,0,0,0,0,0,0,0), 1,0,0,16'h0004,0);
        add(mi(0,0,0,0,0,0,0,0,0,0,1,2,0), 0,0,0,16'h0004,0);
        add(mi(0,1,0,0,0,1,3,0,0,0,0,0,0), 0,0,1,16'h0000,0);
        add(mi(0,1,0,0,0,1,3,0,0,0,1,3,0), 0,0,1,16'h0008,0);
        add(mi(0,0,0,0,0,0,0,0,0,0,0,0,0), 0,0,0,16'h0008,0);
        add(mi(0,0,0,0,0,0,0,0,0,0,1,3,0), 0,0,0,16'h0008,0);
        add(mi(0,1,0,0,0,1,4,0,0,1,0,0,0), 0,1,0,16'h0000,0);
        add(mi(0,1,0,0,0,1,4,0,0,0,0,0,0), 0,1,0,16'h0000,0);
        add(mi(0,0,0,0,0,0,0,0,0,0,0,0,0), 0,0,0,16'h0000,0);
        add(mi(0,0,0,0,0,0,0,0,0,1,0,0,0), 0,1,0,16'h0000,0);
        add(mi(0,0,0,0,0,0,0,0,0,1,0,0,0), 0,1,0,16'h0000,0);
        add(mi(0,0,0,0,0,0,0,0,0,0,0,0,0), 0,1,0,16'h0000,0);
        add(mi(0,0,0,0,0,0,0,0,0,0,0,0,0), 0,0,0,16'h0000,0);
        add(mi(0,1,0,0,0,0,0,1,0,0,0,0,0), 0,0,1,16'h0000,0);
        add(mi(0,1,0,0,0,0,0,0,1,0,0,0,0), 1,0,0,16'h0000,0);
        add(mi(0,1,0,0,0,0,0,0,1,0,0,0,1), 1,0,0,16'h0000,0);
        add(mi(0,1,0,0,0,0,0,0,1,0,0,0,0), 0,0,1,16'h0000,0);
        add(mi(0,0,0,0,0,0,0,0,0,0,1,5,0), 0,0,0,16'h0000,0);
        add(mi(0,0,0,0,0,0,0,0,0,0,0,0,0), 0,0,0,16'h0000,1);
        add(mi(0,0,0,0,0,0,0,0,0,0,0,0,0), 0,0,0,16'h0000,1);
        add(mi(0,1,0,0,0,1,7,0,0,0,0,0,0), 0,0,1,16'h0000,1);
        add(mi(0,0,0,0,0,0,0,0,0,1,0,0,0), 0,1,0,16'h0080,1);
        add(mi(1,1,7,0,0,0,0,0,0,0,0,0,0), 0,0,0,16'h0000,1);
        add(mi(0,1,7,0,0,0,0,0,0,0,0,0,0), 0,0,1,16'h0000,0);
        add(mi(0,1,0,0,0,1,6,0,0,0,0,0,0), 0,0,1,16'h0000,0);
        add(mi(0,1,0,0,0,1,6,0,0,0,0,0,0), 0,0,1,16'h0040,0);
        add(mi(0,1,0,0,0,1,6,0,0,0,0,0,0), 0,0,1,16'h0040,0);
        add(mi(0,1,0,0,0,1,6,0,0,0,0,0,0), 0,0,1,16'h0040,0);
        add(mi(0,0,0,0,0,0,0,0,0,0,0,0,0), 0,0,0,16'h0040,1);
        add(mi(0,0,0,0,0,0,0,0,0,0,1,6,0), 0,0,0,16'h0040,1);
        add(mi(0,0,0,0,0,0,0,0,0,0,1,6,0), 0,0,0,16'h0040,1);
        add(mi(0,0,0,0,0,0,0,0,0,0,1,6,0), 0,0,0,16'h0040,1);
        add(mi(0,0,0,0,0,0,0,0,0,0,0,0,0), 0,0,0,16'h0000,1);

        x = mi(1,0,0,0,0,0,0,0,0,0,0,0,0);
        rst = 1'b1; id_valid = 1'b0; src_1 = '0; src_2 = '0; two_src = 1'b0; id_wb_en = 1'b0;
        id_dest = '0; id_s = 1'b0; id_uses_sr = 1'b0; branch_taken = 1'b0; wb_en = 1'b0;
        wb_dest = '0; wb_sr_en = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        foreach (tbl[n]) step(tbl[n].x, 1'b1, tbl[n].h, tbl[n].f, tbl[n].i, tbl[n].b, tbl[n].e);

        for (int n = 0; n < 3000; n++) begin
            x      = '0;
            x.rst  = ($urandom_range(0, 99) == 0);
            x.v    = ($urandom_range(0, 3) != 0);
            x.s1   = 4'($urandom_range(0, 7));
            x.s2   = 4'($urandom_range(0, 7));
            x.two  = 1'($urandom_range(0, 1));
            x.wen  = 1'($urandom_range(0, 1));
            x.dst  = 4'($urandom_range(0, 7));
            x.s    = ($urandom_range(0, 5) == 0);
            x.usr  = ($urandom_range(0, 3) == 0);
            x.br   = ($urandom_range(0, 11) == 0);
            x.wben = 1'($urandom_range(0, 1));
            base   = $urandom_range(0, 7);
            x.wbd  = 4'(base);
            if ($urandom_range(0, 9) != 0)
                for (int t = 0; t < 8; t++)
                    if (mcnt[(base + t) % 8] != 0) begin
                        x.wbd = 4'((base + t) % 8);
                        break;
                    end
            x.wbsr = (msr > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            step(x, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Scoreboard and pipeline-sequencing controller for the decode stage of the 5-stage ARM pipeline.
- Tracks register-file and status-register writes in flight between ID and WB.
- Drives the ID stage `hazard` input to stall on RAW dependencies, and sequences IF/ID flush on taken branches.
- Sits beside the ID stage; fed by ID decode outputs, the EXE branch signal and the WB write port.

Parameters:
- REG_COUNT, 16, number of architectural registers tracked
- ADDR_W, 4, register address width
- CNT_W, 2, width of each per-register pending counter
- MAX_INFLIGHT, 3, maximum outstanding writes per register (ID→EXE→MEM→WB depth)
- FLUSH_CYCLES, 1, cycles flush is held after a taken branch (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset. Synchronous, active-high.
- id_valid  in  1  ID holds a real instruction
- src_1  in  ADDR_W  first source register (Rn)
- src_2  in  ADDR_W  second source register (Rm, or Rd for stores)
- two_src  in  1  src_2 is read
- id_wb_en  in  1  ID instruction writes a register
- id_dest  in  ADDR_W  ID destination register
- id_s  in  1  ID instruction updates status register
- id_uses_sr  in  1  ID condition field is not AL
- branch_taken  in  1  EXE resolves a taken branch this cycle
- wb_en  in  1  WB writes register file this cycle
- wb_dest  in  ADDR_W  WB destination
- wb_sr_en  in  1  status register written this cycle
- hazard  out  1  stall ID and IF this cycle
- flush  out  1  squash IF/ID contents
- issue  out  1  ID instruction advances to EXE this cycle
- busy_mask  out  REG_COUNT  bit i set when count[i] != 0
- sb_error  out  1  sticky counter overflow/underflow flag

Behaviour:
- State
  - Per-register counter count[i] (CNT_W bits) and status-register counter sr_cnt (CNT_W bits).
  - FSM {RUN, FLUSH} with down-counter fl_cnt.
- Reset: all counters 0, FSM=RUN, fl_cnt=0, sb_error=0. Outputs are forced 0 during reset: hazard, flush, issue, busy_mask.
- Hazard (combinational, same cycle):
  - hazard = id_valid & ~flush & (busy[src_1] | (two_src & busy[src_2]) | (id_uses_sr & sr_cnt!=0)).
  - No WB bypass: a register written by WB this cycle is still busy this cycle and clears next cycle.
- Flush:
  - flush = branch_taken | (FSM==FLUSH).
  - On branch_taken: FSM←FLUSH with fl_cnt←FLUSH_CYCLES-1. If FLUSH_CYCLES=1, FSM stays RUN.
  - In FLUSH: fl_cnt decrements each cycle; at 0, FSM←RUN.
  - branch_taken while in FLUSH reloads fl_cnt.
- Issue: issue = id_valid & ~hazard & ~flush.
- Counter update (registered):
  - On issue & id_wb_en: count[id_dest] +1.
  - On wb_en: count[wb_dest] −1.
  - Same register, same cycle, both events: count unchanged.
  - sr_cnt is updated identically, using issue & id_s and wb_sr_en.
- Error/saturation:
  - Increment at MAX_INFLIGHT: saturate and set sb_error.
  - Decrement at 0: hold 0 and set sb_error.
  - sb_error clears only on rst.
- Flushed instructions are never counted, so no compensating decrement is needed.
- Reset mid-flush: FSM returns to RUN next cycle; all pending counts are discarded.

Decomposition:
- Shared constants header (alongside existing length macros): ADDR_W, REG_COUNT, FSM state encodings RUN/FLUSH.
- One natural sub-module: sb_counter. A single saturating up/down counter with inc, dec, zero and error outputs, instantiated REG_COUNT+1 times (registers plus status register).

Test Plan:
1. Issue R1 write (id_wb_en=1, id_dest=1), next cycle ID reads src_1=1 → hazard=1, issue=0 until the cycle after wb_en with wb_dest=1; busy_mask bit1 goes 1→0.
2. Pending R2; ID with src_2=2, two_src=0 → hazard=0, issue=1. Same instruction with two_src=1 → hazard=1.
3. count[3]=1; same cycle issue to dest 3 and wb_en wb_dest=3 → count[3] stays 1, busy_mask bit3=1, sb_error=0.
4. branch_taken=1 with id_valid=1, id_wb_en=1, id_dest=4, FLUSH_CYCLES=2 → flush=1 for 2 cycles, issue=0, busy_mask bit4 stays 0.
5. id_s issue then id_uses_sr=1 → hazard=1 until wb_sr_en; wb_en with wb_dest=5, count[5]=0 → sb_error=1 and sticky.
6. rst asserted during FLUSH with counts nonzero → next cycle flush=0, busy_mask=0, hazard=0, FSM=RUN.
